// File: rtl/hls_dbg_pkg.sv
// Shared types and helpers for the HLS deadlock debug path.
// State encoding is fixed so that debug tooling can decode the raw state value.
package hls_dbg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WATCH  = 2'd1,
        REPORT = 2'd2,
        HOLD   = 2'd3
    } dl_state_e;

    localparam int unsigned AXIS_W_DEF = 4;
    localparam int unsigned BLK_W_DEF  = 3;
    localparam int unsigned CNT_W_DEF  = 32;
    localparam int unsigned EVT_W_DEF  = 8;

    // Increment v, holding at the all-ones value of a w-bit field.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= max_v) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/hls_sat_counter.sv
// Saturating up-counter with synchronous clear/load and a saturate flag.
// Priority: clear, then load, then increment.
module hls_sat_counter
    import hls_dbg_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt,
    output logic         o_sat
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_inc) begin
            r_cnt <= W'(sat_inc(64'(r_cnt), W));
        end
    end

    assign o_cnt = r_cnt;
    assign o_sat = (r_cnt == '1);

endmodule

// File: rtl/hls_deadlock_report_unit.sv
// Debounces the deadlock monitor's block output, latches a deadlock event with a
// snapshot of the blocking signals, and holds a valid/ack report for debug logic.
module hls_deadlock_report_unit
    import hls_dbg_pkg::*;
#(
    parameter int unsigned AXIS_W    = AXIS_W_DEF,
    parameter int unsigned BLK_W     = BLK_W_DEF,
    parameter int unsigned THRESHOLD = 1024,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned EVT_W     = EVT_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              block_in,
    input  logic [AXIS_W-1:0] axis_block_sigs,
    input  logic [BLK_W-1:0]  inst_block_sigs,
    output logic              deadlock_valid,
    input  logic              deadlock_ack,
    output logic              deadlock_active,
    output logic [AXIS_W-1:0] deadlock_axis_snap,
    output logic [BLK_W-1:0]  deadlock_inst_snap,
    output logic [CNT_W-1:0]  deadlock_duration,
    output logic [EVT_W-1:0]  deadlock_count
);

    dl_state_e         r_state, w_next;
    logic [AXIS_W-1:0] r_axis_snap;
    logic [BLK_W-1:0]  r_inst_snap;

    logic              w_run_clr, w_run_load, w_run_inc, w_run_sat;
    logic              w_dur_load, w_dur_inc, w_dur_sat;
    logic              w_evt_inc, w_evt_sat;
    logic              w_capture;
    logic [CNT_W-1:0]  w_run_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)   r_state <= IDLE;
        else if (clear) r_state <= IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_run_clr  = 1'b0;
        w_run_load = 1'b0;
        w_run_inc  = 1'b0;
        w_dur_load = 1'b0;
        w_dur_inc  = 1'b0;
        w_evt_inc  = 1'b0;
        w_capture  = 1'b0;
        case (r_state)
            IDLE: begin
                if (block_in) begin
                    w_next     = WATCH;
                    w_run_load = 1'b1;
                    w_dur_load = 1'b1;
                end
            end
            WATCH: begin
                if (!block_in) begin
                    w_next    = IDLE;
                    w_run_clr = 1'b1;
                end else if (w_run_cnt == CNT_W'(THRESHOLD - 1)) begin
                    w_next    = REPORT;
                    w_capture = 1'b1;
                    w_evt_inc = 1'b1;
                    w_dur_inc = 1'b1;
                    w_run_clr = 1'b1;
                end else begin
                    w_run_inc = 1'b1;
                    w_dur_inc = 1'b1;
                end
            end
            REPORT: begin
                w_dur_inc = block_in;
                if (deadlock_ack) w_next = block_in ? HOLD : IDLE;
            end
            HOLD: begin
                // Stay here until the episode ends so one stall yields one report.
                if (block_in) w_dur_inc = 1'b1;
                else          w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_axis_snap <= '0;
            r_inst_snap <= '0;
        end else if (clear) begin
            r_axis_snap <= '0;
            r_inst_snap <= '0;
        end else if (w_capture) begin
            r_axis_snap <= axis_block_sigs;
            r_inst_snap <= inst_block_sigs;
        end
    end

    hls_sat_counter #(.W(CNT_W)) u_run_cnt (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_clr      (clear | w_run_clr),
        .i_load     (w_run_load),
        .i_load_val (CNT_W'(1)),
        .i_inc      (w_run_inc & ~w_run_sat),
        .o_cnt      (w_run_cnt),
        .o_sat      (w_run_sat)
    );

    hls_sat_counter #(.W(CNT_W)) u_dur_cnt (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_clr      (clear),
        .i_load     (w_dur_load),
        .i_load_val (CNT_W'(1)),
        .i_inc      (w_dur_inc & ~w_dur_sat),
        .o_cnt      (deadlock_duration),
        .o_sat      (w_dur_sat)
    );

    hls_sat_counter #(.W(EVT_W)) u_evt_cnt (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_clr      (clear),
        .i_load     (1'b0),
        .i_load_val (EVT_W'(0)),
        .i_inc      (w_evt_inc & ~w_evt_sat),
        .o_cnt      (deadlock_count),
        .o_sat      (w_evt_sat)
    );

    assign deadlock_valid     = (r_state == REPORT);
    assign deadlock_active    = (r_state == REPORT) || (r_state == HOLD);
    assign deadlock_axis_snap = r_axis_snap;
    assign deadlock_inst_snap = r_inst_snap;

endmodule

// File: tb/tb_hls_deadlock_report_unit.sv
// Directed bench: stimulus pushes expected reports into a queue, a monitor pops
// and checks them on each new deadlock_valid; state/counter checks are inline.
module tb_hls_deadlock_report_unit;

    typedef struct packed {
        logic [3:0] axis;
        logic [2:0] inst;
        logic [7:0] cnt;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n, clear, block_in, deadlock_ack;
    logic [3:0] axis_block_sigs;
    logic [2:0] inst_block_sigs;

    logic        m_valid, m_active;
    logic [3:0]  m_axis_snap;
    logic [2:0]  m_inst_snap;
    logic [31:0] m_dur;
    logic [7:0]  m_cnt;

    logic        s_valid, s_active;
    logic [3:0]  s_axis_snap;
    logic [2:0]  s_inst_snap;
    logic [2:0]  s_dur;
    logic [1:0]  s_cnt;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t q[$];
    exp_t cur;
    logic prev_valid;
    logic [7:0] exp_cnt;

    always #5 clock = ~clock;

    hls_deadlock_report_unit #(.AXIS_W(4), .BLK_W(3), .THRESHOLD(4), .CNT_W(32), .EVT_W(8)) u_dut (
        .clock(clock), .reset_n(reset_n), .clear(clear), .block_in(block_in),
        .axis_block_sigs(axis_block_sigs), .inst_block_sigs(inst_block_sigs),
        .deadlock_valid(m_valid), .deadlock_ack(deadlock_ack), .deadlock_active(m_active),
        .deadlock_axis_snap(m_axis_snap), .deadlock_inst_snap(m_inst_snap),
        .deadlock_duration(m_dur), .deadlock_count(m_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation behaviour.
    hls_deadlock_report_unit #(.AXIS_W(4), .BLK_W(3), .THRESHOLD(4), .CNT_W(3), .EVT_W(2)) u_sat (
        .clock(clock), .reset_n(reset_n), .clear(clear), .block_in(block_in),
        .axis_block_sigs(axis_block_sigs), .inst_block_sigs(inst_block_sigs),
        .deadlock_valid(s_valid), .deadlock_ack(deadlock_ack), .deadlock_active(s_active),
        .deadlock_axis_snap(s_axis_snap), .deadlock_inst_snap(s_inst_snap),
        .deadlock_duration(s_dur), .deadlock_count(s_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [3:0] a, input logic [2:0] i, input logic [7:0] c);
        exp_t e;
        e.axis = a;
        e.inst = i;
        e.cnt  = c;
        q.push_back(e);
    endtask

    // Monitor: a new report pops the scoreboard; a held report must keep its snapshot.
    initial begin
        prev_valid = 1'b0;
        cur        = '0;
        forever begin
            @(negedge clock);
            if (m_valid && !prev_valid) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_unexpected_report: got report axis=%0h cnt=%0h expected none",
                             m_axis_snap, m_cnt);
                end else begin
                    cur = q.pop_front();
                    chk("sb_axis_snap", 32'(m_axis_snap), 32'(cur.axis));
                    chk("sb_inst_snap", 32'(m_inst_snap), 32'(cur.inst));
                    chk("sb_count",     32'(m_cnt),       32'(cur.cnt));
                end
            end else if (m_valid) begin
                chk("snap_axis_stable", 32'(m_axis_snap), 32'(cur.axis));
                chk("snap_inst_stable", 32'(m_inst_snap), 32'(cur.inst));
            end
            prev_valid = m_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; clear = 1'b0; block_in = 1'b1; deadlock_ack = 1'b0;
        axis_block_sigs = 4'hF; inst_block_sigs = 3'h7; exp_cnt = 8'd0;
        #12;
        chk("rst_valid",  32'(m_valid),     32'd0);
        chk("rst_active", 32'(m_active),    32'd0);
        chk("rst_axis",   32'(m_axis_snap), 32'd0);
        chk("rst_inst",   32'(m_inst_snap), 32'd0);
        chk("rst_dur",    m_dur,            32'd0);
        chk("rst_cnt",    32'(m_cnt),       32'd0);
        chk("rst_s_cnt",  32'(s_cnt),       32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Detection latency and snapshot taken on the detecting edge only.
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("latency_no_early_valid", 32'(m_valid), 32'd0);
        end
        axis_block_sigs = 4'b0101; inst_block_sigs = 3'b010;
        exp_cnt = 8'd1; push(4'b0101, 3'b010, exp_cnt);
        cyc();
        chk("latency_valid_k3", 32'(m_valid), 32'd1);
        chk("dur_at_detect",    m_dur,        32'd4);
        axis_block_sigs = 4'b1010; inst_block_sigs = 3'b101;
        repeat (4) cyc();
        chk("report_held", 32'(m_valid), 32'd1);

        // Ack while still blocked parks in HOLD without re-reporting.
        deadlock_ack = 1'b1; cyc(); deadlock_ack = 1'b0;
        chk("hold_valid",  32'(m_valid),  32'd0);
        chk("hold_active", 32'(m_active), 32'd1);
        chk("hold_dur",    m_dur,         32'd9);
        repeat (2) cyc();
        chk("hold_no_rereport", 32'(m_valid),  32'd0);
        chk("hold_active2",     32'(m_active), 32'd1);
        chk("hold_dur2",        m_dur,         32'd11);
        block_in = 1'b0; cyc();
        chk("hold_exit_active", 32'(m_active), 32'd0);
        cyc();
        chk("dur_frozen", m_dur, 32'd11);

        block_in = 1'b1; repeat (3) cyc();
        axis_block_sigs = 4'h3; inst_block_sigs = 3'h6;
        exp_cnt = 8'd2; push(4'h3, 3'h6, exp_cnt);
        cyc();
        chk("second_report_valid", 32'(m_valid), 32'd1);
        chk("second_report_cnt",   32'(m_cnt),   32'd2);

        // Clear during REPORT drops everything without an ack.
        clear = 1'b1; block_in = 1'b0; cyc(); clear = 1'b0;
        exp_cnt = 8'd0;
        chk("clr_valid",  32'(m_valid),     32'd0);
        chk("clr_active", 32'(m_active),    32'd0);
        chk("clr_cnt",    32'(m_cnt),       32'd0);
        chk("clr_axis",   32'(m_axis_snap), 32'd0);
        chk("clr_inst",   32'(m_inst_snap), 32'd0);
        chk("clr_dur",    m_dur,            32'd0);

        // Short stall below threshold.
        block_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("short_no_valid", 32'(m_valid), 32'd0);
        end
        block_in = 1'b0; cyc();
        chk("short_valid", 32'(m_valid), 32'd0);
        chk("short_cnt",   32'(m_cnt),   32'd0);
        chk("short_dur",   m_dur,        32'd3);

        // One-cycle glitch restarts the debounce.
        axis_block_sigs = 4'h9; inst_block_sigs = 3'h1;
        block_in = 1'b1; repeat (2) cyc();
        block_in = 1'b0; cyc();
        block_in = 1'b1; repeat (3) cyc();
        chk("glitch_restart", 32'(m_valid), 32'd0);
        exp_cnt = 8'd1; push(4'h9, 3'h1, exp_cnt);
        cyc();
        chk("glitch_then_valid", 32'(m_valid), 32'd1);
        chk("glitch_dur",        m_dur,        32'd4);

        // Ack together with block dropping goes straight to IDLE.
        deadlock_ack = 1'b1; block_in = 1'b0; cyc(); deadlock_ack = 1'b0;
        chk("ack_drop_active", 32'(m_active), 32'd0);
        chk("ack_drop_dur",    m_dur,         32'd4);

        // Ack held through IDLE/WATCH is ignored until the report exists.
        deadlock_ack = 1'b1; cyc();
        axis_block_sigs = 4'hC; inst_block_sigs = 3'h4;
        block_in = 1'b1; repeat (3) cyc();
        chk("early_ack_ignored", 32'(m_valid), 32'd0);
        exp_cnt = 8'd2; push(4'hC, 3'h4, exp_cnt);
        cyc();
        chk("early_ack_report", 32'(m_valid), 32'd1);
        block_in = 1'b0; cyc(); deadlock_ack = 1'b0;
        chk("early_ack_idle", 32'(m_active), 32'd0);

        // Event counter saturation on the 2-bit instance.
        clear = 1'b1; cyc(); clear = 1'b0; exp_cnt = 8'd0;
        for (int e = 0; e < 5; e++) begin
            axis_block_sigs = 4'(e + 1); inst_block_sigs = 3'(e + 2);
            block_in = 1'b1; repeat (3) cyc();
            exp_cnt = exp_cnt + 8'd1;
            push(4'(e + 1), 3'(e + 2), exp_cnt);
            cyc();
            chk("sat_evt_report", 32'(s_valid), 32'd1);
            deadlock_ack = 1'b1; block_in = 1'b0; cyc(); deadlock_ack = 1'b0;
        end
        chk("sat_evt_cnt",  32'(s_cnt), 32'd3);
        chk("main_evt_cnt", 32'(m_cnt), 32'd5);

        // Duration saturation on the 3-bit instance: 12 blocked cycles.
        clear = 1'b1; cyc(); clear = 1'b0;
        axis_block_sigs = 4'h7; inst_block_sigs = 3'h3;
        block_in = 1'b1; repeat (3) cyc();
        exp_cnt = 8'd1; push(4'h7, 3'h3, exp_cnt);
        repeat (9) cyc();
        chk("sat_dur",  32'(s_dur), 32'd7);
        chk("main_dur", m_dur,      32'd12);
        deadlock_ack = 1'b1; block_in = 1'b0; cyc(); deadlock_ack = 1'b0;
        repeat (2) cyc();

        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hls_deadlock_report_unit.md
Name: hls_deadlock_report_unit

Overview:
- Consumes the registered `block` output of the top-level HLS deadlock monitor for the v_tpg instance.
- Acts as the stage directly downstream of that monitor: debounces `block` against a persistence threshold, then latches a deadlock event.
- Captures a snapshot of the blocking AXIS and instance signals and presents a valid/ack report to the debug/interrupt logic.
- Keeps a saturating event count and a saturating blocked-duration measurement.

Parameters:
- AXIS_W, 4: width of the axis_block_sigs snapshot.
- BLK_W, 3: width of the inst_block_sigs snapshot.
- THRESHOLD, 1024: consecutive block cycles required to declare deadlock; legal range is 2 to 2^CNT_W-1.
- CNT_W, 32: width of the duration counter.
- EVT_W, 8: width of the event counter.

Ports:
- clock  in  1  single clock; all state is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of latched state and counters.
- block_in  in  1  block output of the deadlock monitor.
- axis_block_sigs  in  AXIS_W  per-channel AXIS blocked flags.
- inst_block_sigs  in  BLK_W  per-instance blocked flags.
- deadlock_valid  out  1  report available.
- deadlock_ack  in  1  report consumed (handshake with deadlock_valid).
- deadlock_active  out  1  high while state is REPORT or HOLD.
- deadlock_axis_snap  out  AXIS_W  axis_block_sigs captured at detection.
- deadlock_inst_snap  out  BLK_W  inst_block_sigs captured at detection.
- deadlock_duration  out  CNT_W  consecutive block cycles of the current or last episode.
- deadlock_count  out  EVT_W  number of deadlocks declared, saturating.

Behaviour:
- Reset: asynchronous assertion on reset_n=0; synchronous deassertion is guaranteed externally. While reset is asserted:
  - all outputs are 0;
  - state is IDLE;
  - all counters are 0.
- clear has priority over all other inputs. It has the same effect as reset, taking effect on the next edge, and is legal in any state, including mid-REPORT. deadlock_valid drops the cycle after clear, with no ack needed.
- FSM states: IDLE, WATCH, REPORT, HOLD.
- IDLE:
  - block_in=1 -> WATCH; run counter=1; duration=1.
  - Otherwise stay in IDLE; duration holds its last value.
- WATCH:
  - block_in=0 -> IDLE; run counter=0; no report.
  - block_in=1 and run counter=THRESHOLD-1 -> REPORT. On that same edge: capture axis_block_sigs and inst_block_sigs into the snapshots; increment deadlock_count, saturating at all-ones.
  - Otherwise increment run counter and duration.
- REPORT:
  - deadlock_valid=1; it stays high until deadlock_ack is sampled high.
  - Snapshots are stable for the whole state.
  - On ack: block_in=1 -> HOLD; block_in=0 -> IDLE.
- HOLD:
  - Waits for block_in=0, then goes to IDLE. This prevents re-reporting a single episode.
- Duration rules:
  - Increments on every cycle with block_in=1 in WATCH, REPORT or HOLD.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Frozen once block_in=0.
  - Reloaded to 1 only on IDLE->WATCH.
- Latency: if block_in is first sampled high at edge k and stays high, the transition IDLE->WATCH occurs at edge k. REPORT is entered and deadlock_valid is registered high at edge k+THRESHOLD-1.
- Simultaneous events:
  - block_in dropping in the same cycle as the ack in REPORT -> IDLE directly.
  - ack sampled while deadlock_valid=0 is ignored.
  - block_in glitch low for 1 cycle in WATCH restarts detection fully.
- deadlock_count at all-ones: further deadlocks still produce reports, but the count does not change.

Decomposition:
- Shared package hls_dbg_pkg holds:
  - the state enum (IDLE=2'd0, WATCH=2'd1, REPORT=2'd2, HOLD=2'd3);
  - default widths AXIS_W/BLK_W/CNT_W/EVT_W;
  - a saturating-increment function.
- One natural sub-module, hls_sat_counter (parameterised width, inc/load/clear, saturate flag). It is instantiated for the duration and event counters; the run counter reuses it.

Test Plan:
- Reset/idle: reset_n=0 with block_in=1 -> all outputs 0; after release, valid asserts exactly THRESHOLD-1 edges after block_in is first sampled high (THRESHOLD=4 -> edge k+3).
- Short stall: THRESHOLD=4, block_in high 3 cycles then low -> deadlock_valid never asserts, count=0, duration=3.
- Detection plus snapshot:
  - Stimulus: THRESHOLD=4, axis_block_sigs=4'b0101, inst_block_sigs=3'b010 on the detecting edge, block_in held high.
  - Response: valid=1, axis_snap=0101, inst_snap=010, count=1.
  - Snapshots must stay constant while inputs change during REPORT.
- Ack with block still high: ack after 5 REPORT cycles with block_in=1 -> HOLD, valid=0, active=1, no second report until block_in drops and re-asserts for 4 more cycles (count=2).
- Clear mid-REPORT: assert clear with valid=1 -> next cycle valid=0, count=0, snapshots=0, state IDLE.
- Saturation: EVT_W=2, 5 separate deadlocks -> count stays at 3; CNT_W=3 with block held 12 cycles -> duration=7.
